// File: rtl/f11_vic.sv
// rtl/f11_vic.sv - vectored interrupt controller for the F-11 Wishbone core
// Merges level requests into vm_virq[7:4] and serves vector / fast-data reads.
module f11_vic #(
  parameter int          VIC_N    = 8,
  parameter logic [15:0] VIC_SPUR = 16'o0
) (
  input  logic                 vm_clk_p,
  input  logic                 vm_init,
  input  logic [VIC_N-1:0]     irq_req,
  input  logic [2*VIC_N-1:0]   irq_lvl,
  input  logic [16*VIC_N-1:0]  irq_vec,
  output logic [VIC_N-1:0]     irq_ack,
  input  logic [15:0]          fdin_dat,
  output logic [7:4]           vm_virq,
  input  logic                 wbi_stb_i,
  input  logic                 wbi_una_i,
  output logic [15:0]          wbi_dat_o,
  output logic                 wbi_ack_o
);

  localparam int WW = (VIC_N > 1) ? $clog2(VIC_N) : 1;

  typedef enum logic [1:0] {IDLE, LATCH, ACK, WAIT} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          una_q;
  logic          hit_q;
  logic [WW-1:0] win_q;
  logic [WW-1:0] win_idx;
  logic          win_vld;
  logic [1:0]    win_lvl;
  logic [3:0]    virq_nxt;

  // Strict '>' keeps the lowest index among equal-level requesters.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_lvl = 2'd0;
    for (int i = 0; i < VIC_N; i++) begin
      if (irq_req[i] && (!win_vld || (irq_lvl[2*i +: 2] > win_lvl))) begin
        win_vld = 1'b1;
        win_idx = WW'(i);
        win_lvl = irq_lvl[2*i +: 2];
      end
    end
  end

  always_comb begin
    virq_nxt = 4'd0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < VIC_N; i++) begin
        if (irq_req[i] && (irq_lvl[2*i +: 2] == 2'(k))) begin
          virq_nxt[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge vm_clk_p) begin
    if (vm_init) begin
      vm_virq <= 4'd0;
    end else begin
      vm_virq <= virq_nxt;
    end
  end

  always_ff @(posedge vm_clk_p) begin
    if (vm_init) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wbi_stb_i) state_nxt = LATCH;
      LATCH:   state_nxt = wbi_stb_i ? ACK : IDLE;
      ACK:     state_nxt = WAIT;
      WAIT:    if (!wbi_stb_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The read result is frozen here so late request changes cannot alter it.
  always_ff @(posedge vm_clk_p) begin
    if (vm_init) begin
      una_q     <= 1'b0;
      hit_q     <= 1'b0;
      win_q     <= '0;
      wbi_dat_o <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (wbi_stb_i) una_q <= wbi_una_i;
        end
        LATCH: begin
          if (una_q) begin
            wbi_dat_o <= fdin_dat;
            hit_q     <= 1'b0;
          end else if (win_vld) begin
            wbi_dat_o <= irq_vec[16*win_idx +: 16];
            hit_q     <= 1'b1;
            win_q     <= win_idx;
          end else begin
            wbi_dat_o <= VIC_SPUR;
            hit_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wbi_ack_o = (state == ACK);
    irq_ack   = '0;
    if ((state == ACK) && hit_q) begin
      irq_ack[win_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_f11_vic.sv
// tb/tb_f11_vic.sv - randomized self-checking bench for f11_vic
// Reference model: level summary and priority winner derived from channel tables.
module tb_f11_vic;

  localparam int          N    = 8;
  localparam logic [15:0] SPUR = 16'o0;

  logic            clk = 1'b0;
  logic            vm_init = 1'b1;
  logic [N-1:0]    irq_req = '0;
  logic [2*N-1:0]  irq_lvl = '0;
  logic [16*N-1:0] irq_vec = '0;
  logic [N-1:0]    irq_ack;
  logic [15:0]     fdin_dat = '0;
  logic [7:4]      vm_virq;
  logic            wbi_stb_i = 1'b0;
  logic            wbi_una_i = 1'b0;
  logic [15:0]     wbi_dat_o;
  logic            wbi_ack_o;

  int checks = 0;
  int errors = 0;

  f11_vic #(.VIC_N(N), .VIC_SPUR(SPUR)) dut (
    .vm_clk_p (clk),
    .vm_init  (vm_init),
    .irq_req  (irq_req),
    .irq_lvl  (irq_lvl),
    .irq_vec  (irq_vec),
    .irq_ack  (irq_ack),
    .fdin_dat (fdin_dat),
    .vm_virq  (vm_virq),
    .wbi_stb_i(wbi_stb_i),
    .wbi_una_i(wbi_una_i),
    .wbi_dat_o(wbi_dat_o),
    .wbi_ack_o(wbi_ack_o)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_virq();
    logic [3:0] v = 4'd0;
    for (int i = 0; i < N; i++)
      if (irq_req[i]) v[int'(irq_lvl[2*i +: 2])] = 1'b1;
    return v;
  endfunction

  function automatic int m_winner();
    for (int lv = 3; lv >= 0; lv--)
      for (int i = 0; i < N; i++)
        if (irq_req[i] && int'(irq_lvl[2*i +: 2]) == lv) return i;
    return -1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic req, input logic [1:0] lvl, input logic [15:0] vec);
    irq_req[ch]         = req;
    irq_lvl[2*ch +: 2]  = lvl;
    irq_vec[16*ch +: 16] = vec;
  endtask

  // Drives one strobe held for 'hold' cycles and records what came back.
  task automatic run_read(input logic una, input int hold, output logic [15:0] dat,
                          output int nack, output int first_ack, output logic [N-1:0] iack);
    dat = 16'hxxxx; nack = 0; first_ack = -1; iack = '0;
    wbi_stb_i = 1'b1;
    wbi_una_i = una;
    for (int c = 0; c < hold + 4; c++) begin
      @(negedge clk);
      if (wbi_ack_o) begin
        nack++;
        if (first_ack < 0) first_ack = c;
        dat = wbi_dat_o;
      end
      iack |= irq_ack;
      @(posedge clk); #1;
      if (c == hold - 1) begin
        wbi_stb_i = 1'b0;
        wbi_una_i = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    vm_init = 1'b1;
    step(3);
    checks++; if (wbi_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", wbi_ack_o); end
    checks++; if (irq_ack !== '0) begin errors++; $display("FAIL reset_irq_ack got %h exp 0", irq_ack); end
    checks++; if (vm_virq !== 4'd0) begin errors++; $display("FAIL reset_virq got %b exp 0", vm_virq); end
    checks++; if (wbi_dat_o !== 16'd0) begin errors++; $display("FAIL reset_dat got %h exp 0", wbi_dat_o); end
    vm_init = 1'b0;
    step(1);
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    irq_req = '0;
    set_ch(0, 1'b1, 2'd2, 16'o000100);
    step(2);
    wbi_stb_i = 1'b1;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (wbi_ack_o) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_reach_ack got 0 exp 1"); end
    vm_init = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (wbi_ack_o !== 1'b0) begin errors++; $display("FAIL mid_reset_ack got %b exp 0", wbi_ack_o); end
    checks++; if (irq_ack !== '0) begin errors++; $display("FAIL mid_reset_irq_ack got %h exp 0", irq_ack); end
    checks++; if (vm_virq !== 4'd0) begin errors++; $display("FAIL mid_reset_virq got %b exp 0", vm_virq); end
    wbi_stb_i = 1'b0;
    irq_req = '0;
    @(posedge clk); #1;
    vm_init = 1'b0;
    step(2);
  endtask

  task automatic test_single();
    logic [15:0] d; int na, fa; logic [N-1:0] ia;
    irq_req = '0;
    set_ch(2, 1'b1, 2'd1, 16'o000060);
    step(1);
    checks++; if (vm_virq !== 4'b0010) begin errors++; $display("FAIL single_virq got %b exp 0010", vm_virq); end
    run_read(1'b0, 3, d, na, fa, ia);
    checks++; if (fa !== 2) begin errors++; $display("FAIL single_latency got %0d exp 2", fa); end
    checks++; if (d !== 16'o000060) begin errors++; $display("FAIL single_dat got %o exp 60", d); end
    checks++; if (ia !== 8'h04) begin errors++; $display("FAIL single_irq_ack got %h exp 04", ia); end
    checks++; if (na !== 1) begin errors++; $display("FAIL single_nack got %0d exp 1", na); end
  endtask

  task automatic test_priority();
    logic [15:0] d; int na, fa; logic [N-1:0] ia;
    logic [15:0] exp_v [3] = '{16'o000500, 16'o000600, 16'o000100};
    int          exp_c [3] = '{5, 6, 1};
    irq_req = '0;
    set_ch(1, 1'b1, 2'd0, 16'o000100);
    set_ch(5, 1'b1, 2'd3, 16'o000500);
    set_ch(6, 1'b1, 2'd3, 16'o000600);
    step(1);
    for (int r = 0; r < 3; r++) begin
      run_read(1'b0, 3, d, na, fa, ia);
      checks++; if (d !== exp_v[r]) begin errors++; $display("FAIL prio_dat_%0d got %o exp %o", r, d, exp_v[r]); end
      checks++; if (ia !== N'(1 << exp_c[r])) begin errors++; $display("FAIL prio_irq_ack_%0d got %h exp %h", r, ia, N'(1 << exp_c[r])); end
      irq_req[exp_c[r]] = 1'b0;
      step(1);
    end
  endtask

  task automatic test_spurious_fast();
    logic [15:0] d; int na, fa; logic [N-1:0] ia;
    irq_req = '0;
    step(1);
    run_read(1'b0, 3, d, na, fa, ia);
    checks++; if (d !== SPUR) begin errors++; $display("FAIL spur_dat got %o exp %o", d, SPUR); end
    checks++; if (na !== 1) begin errors++; $display("FAIL spur_nack got %0d exp 1", na); end
    checks++; if (ia !== '0) begin errors++; $display("FAIL spur_irq_ack got %h exp 0", ia); end
    fdin_dat = 16'o173400;
    set_ch(4, 1'b1, 2'd2, 16'o000444);
    run_read(1'b1, 3, d, na, fa, ia);
    checks++; if (d !== 16'o173400) begin errors++; $display("FAIL fast_dat got %o exp 173400", d); end
    checks++; if (na !== 1) begin errors++; $display("FAIL fast_nack got %0d exp 1", na); end
    checks++; if (ia !== '0) begin errors++; $display("FAIL fast_irq_ack got %h exp 0", ia); end
    fdin_dat = 16'o007777;
    step(3);
    checks++; if (wbi_dat_o !== 16'o173400) begin errors++; $display("FAIL dat_hold got %o exp 173400", wbi_dat_o); end
    irq_req = '0;
  endtask

  task automatic test_stretch_drop();
    logic [15:0] d; int na, fa; logic [N-1:0] ia;
    irq_req = '0;
    set_ch(3, 1'b1, 2'd2, 16'o001234);
    step(2);
    run_read(1'b0, 10, d, na, fa, ia);
    checks++; if (na !== 1) begin errors++; $display("FAIL stretch_nack got %0d exp 1", na); end
    checks++; if (d !== 16'o001234) begin errors++; $display("FAIL stretch_dat got %o exp 1234", d); end
    // strobe gone during LATCH: no acknowledge at all
    run_read(1'b0, 1, d, na, fa, ia);
    checks++; if (na !== 0) begin errors++; $display("FAIL abort_nack got %0d exp 0", na); end
    checks++; if (ia !== '0) begin errors++; $display("FAIL abort_irq_ack got %h exp 0", ia); end
    // request removed once the vector has been latched
    wbi_stb_i = 1'b1;
    step(2);
    irq_req[3] = 1'b0;
    @(negedge clk);
    checks++; if (wbi_ack_o !== 1'b1) begin errors++; $display("FAIL drop_ack got %b exp 1", wbi_ack_o); end
    checks++; if (wbi_dat_o !== 16'o001234) begin errors++; $display("FAIL drop_dat got %o exp 1234", wbi_dat_o); end
    checks++; if (irq_ack !== 8'h08) begin errors++; $display("FAIL drop_irq_ack got %h exp 08", irq_ack); end
    @(posedge clk); #1;
    wbi_stb_i = 1'b0;
    step(3);
  endtask

  task automatic test_random();
    logic [15:0] d, ev; int na, fa, w, hold; logic [N-1:0] ia, ei; logic una;
    for (int it = 0; it < 40; it++) begin
      irq_req  = N'($urandom);
      irq_lvl  = (2*N)'($urandom);
      for (int i = 0; i < N; i++) irq_vec[16*i +: 16] = 16'($urandom);
      fdin_dat = 16'($urandom);
      una      = ($urandom_range(0, 3) == 0);
      hold     = $urandom_range(2, 6);
      step(1);
      checks++; if (vm_virq !== m_virq()) begin errors++; $display("FAIL rnd_virq_%0d got %b exp %b", it, vm_virq, m_virq()); end
      w  = m_winner();
      ev = una ? fdin_dat : (w < 0 ? SPUR : irq_vec[16*w +: 16]);
      ei = (una || w < 0) ? '0 : N'(1 << w);
      run_read(una, hold, d, na, fa, ia);
      checks++; if (d !== ev) begin errors++; $display("FAIL rnd_dat_%0d got %h exp %h", it, d, ev); end
      checks++; if (ia !== ei) begin errors++; $display("FAIL rnd_irq_ack_%0d got %h exp %h", it, ia, ei); end
      checks++; if (na !== 1 || fa !== 2) begin errors++; $display("FAIL rnd_ack_%0d got n=%0d lat=%0d exp n=1 lat=2", it, na, fa); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_single();
    test_priority();
    test_spurious_fast();
    test_stretch_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
